// File: rtl/uart_tx.sv
// Byte-serialising UART transmitter: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits. Paced by one-cycle ticks from a gated baud generator.
module uart_tx #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data,
    input  logic       start,
    input  logic       baud_tick,
    output logic       baud_ena,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam int NBITS = 1 + 8 + PARITY_EN + STOP_BITS;
    localparam int SW    = 12;
    localparam int CW    = 4;

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [SW-1:0] shreg;
    logic [CW-1:0] cnt;

    // Whole frame in transmit order; unused upper slots stay 1 so stop bits fall out naturally.
    function automatic logic [SW-1:0] build_frame(input logic [7:0] d);
        logic [SW-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (PARITY_EN != 0) f[9] = (^d) ^ 1'(PARITY_ODD);
        return f;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tx       <= 1'b1;
            ready    <= 1'b1;
            baud_ena <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            shreg    <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= build_frame(data);
                        cnt      <= '0;
                        state    <= BUSY;
                        ready    <= 1'b0;
                        baud_ena <= 1'b1;
                    end
                end
                BUSY: begin
                    if (baud_tick) begin
                        // The tick after the last bit closes the final stop bit.
                        if (cnt == CW'(NBITS)) begin
                            state    <= IDLE;
                            ready    <= 1'b1;
                            baud_ena <= 1'b0;
                            done     <= 1'b1;
                            tx       <= 1'b1;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= {1'b1, shreg[SW-1:1]};
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
